// File: rtl/conv_pkg.sv
// Shared constants, state type and helpers for the convolution/deconvolution datapaths.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package conv_pkg;

  localparam int CONV_W     = 16;
  localparam int CONV_NTAPS = 8;
  localparam int CONV_XLEN  = 8;

  // Number of y samples one deconvolution frame consumes.
  function automatic int frame_len(input int xlen, input int ntaps);
    return xlen + ntaps - 1;
  endfunction

  localparam int CONV_FRAME_LEN = CONV_XLEN + CONV_NTAPS - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_Y,
    ST_MAC,
    ST_EMIT,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/deconv_mac.sv
// Registered accumulator: loads a y sample, then subtracts one low-W product per step.
// Latency: result visible one cycle after load/step.
// Backpressure: none; the caller sequences load/step.
module deconv_mac
  import conv_pkg::*;
#(
  parameter int W = CONV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] coef,
  input  logic [W-1:0] xval,
  output logic [W-1:0] acc
);

  // Only the low W bits of the product matter; everything wraps modulo 2^W.
  logic [W-1:0] prod;
  assign prod = coef * xval;

  // Accumulator: a load takes priority over a subtract step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (step) begin
      acc <= acc - prod;
    end
  end

endmodule

// File: rtl/deconv_engine.sv
// Recovers x[0..XLEN-1] from a streamed convolution result using a monic kernel (h[0]=1).
// Latency: x_valid 1+min(n,NTAPS-1) cycles after y[n] is accepted; tail samples only checked.
// Backpressure: y_ready only while waiting for a sample; x_data held stable while x_ready is low.
module deconv_engine
  import conv_pkg::*;
#(
  parameter int W     = CONV_W,
  parameter int NTAPS = CONV_NTAPS,
  parameter int XLEN  = CONV_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     h_we,
  input  logic [$clog2(NTAPS)-1:0] h_idx,
  input  logic [W-1:0]             h_data,
  input  logic                     start,
  input  logic                     y_valid,
  output logic                     y_ready,
  input  logic [W-1:0]             y_data,
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic [W-1:0]             x_data,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch
);

  localparam int FRAME = frame_len(XLEN, NTAPS);
  localparam int KW    = $clog2(NTAPS);
  localparam int NW    = $clog2(FRAME + 1);

  state_t        state;
  logic [NW-1:0] n;
  logic [NW-1:0] k;
  logic [NW-1:0] k_last;
  logic [W-1:0]  taps [1:NTAPS-1];
  // hist[j] holds x[n-j]; zeros are shifted in during the tail so the index stays k.
  logic [W-1:0]  hist [1:NTAPS-1];
  logic [W-1:0]  acc;

  logic [NW-1:0] k_first;
  logic [NW-1:0] k_last_n;
  logic          has_terms;
  logic          in_body;
  logic          y_take;

  // Range of kernel indices whose x[n-k] lies inside the recovered sequence.
  always_comb begin
    k_first  = NW'(1);
    k_last_n = n;
    if (n >= NW'(XLEN)) begin
      k_first = n - NW'(XLEN) + NW'(1);
    end
    if (n >= NW'(NTAPS - 1)) begin
      k_last_n = NW'(NTAPS - 1);
    end
  end

  assign has_terms = (k_last_n >= k_first);
  assign in_body   = (n < NW'(XLEN));
  assign y_take    = (state == ST_WAIT_Y) && y_valid && y_ready;
  assign x_data    = acc;

  deconv_mac #(.W(W)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .load     (y_take),
    .load_val (y_data),
    .step     (state == ST_MAC),
    .coef     (taps[k[KW-1:0]]),
    .xval     (hist[k[KW-1:0]]),
    .acc      (acc)
  );

  // Frame sequencer, tap storage and x history; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      n        <= '0;
      k        <= NW'(1);
      k_last   <= NW'(1);
      y_ready  <= 1'b0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      for (int i = 1; i < NTAPS; i++) begin
        taps[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT_Y;
            n        <= '0;
            mismatch <= 1'b0;
            busy     <= 1'b1;
            y_ready  <= 1'b1;
            for (int i = 1; i < NTAPS; i++) begin
              hist[i] <= '0;
            end
          end else if (h_we && (h_idx != '0)) begin
            taps[h_idx] <= h_data;
          end
        end
        ST_WAIT_Y: begin
          if (y_valid) begin
            y_ready <= 1'b0;
            k       <= k_first;
            k_last  <= k_last_n;
            if (has_terms) begin
              state <= ST_MAC;
            end else if (in_body) begin
              state   <= ST_EMIT;
              x_valid <= 1'b1;
            end else begin
              state <= ST_CHECK;
            end
          end
        end
        ST_MAC: begin
          if (k == k_last) begin
            if (in_body) begin
              state   <= ST_EMIT;
              x_valid <= 1'b1;
            end else begin
              state <= ST_CHECK;
            end
          end else begin
            k <= k + NW'(1);
          end
        end
        ST_EMIT: begin
          if (x_ready) begin
            x_valid <= 1'b0;
            hist[1] <= acc;
            for (int i = NTAPS - 1; i > 1; i--) begin
              hist[i] <= hist[i-1];
            end
            n       <= n + NW'(1);
            state   <= ST_WAIT_Y;
            y_ready <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (acc != '0) begin
            mismatch <= 1'b1;
          end
          hist[1] <= '0;
          for (int i = NTAPS - 1; i > 1; i--) begin
            hist[i] <= hist[i-1];
          end
          n <= n + NW'(1);
          if (n + NW'(1) == NW'(FRAME)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state   <= ST_WAIT_Y;
            y_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deconv_engine.sv
// Bench for deconv_engine: frames driven with random handshakes, compared to a direct recursion model.
// Latency: checked for first and last body samples.
// Backpressure: random x_ready/y_valid plus a forced stall at n=2.
module tb_deconv_engine;

  localparam int W  = 16;
  localparam int NT = 8;
  localparam int XL = 8;
  localparam int FL = XL + NT - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         h_we = 1'b0;
  logic [2:0]   h_idx = '0;
  logic [W-1:0] h_data = '0;
  logic         start = 1'b0;
  logic         y_valid = 1'b0;
  logic         y_ready;
  logic [W-1:0] y_data = '0;
  logic         x_valid;
  logic         x_ready = 1'b0;
  logic [W-1:0] x_data;
  logic         busy, done, mismatch;

  always #5 clk = ~clk;

  deconv_engine #(.W(W), .NTAPS(NT), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .h_we(h_we), .h_idx(h_idx), .h_data(h_data),
    .start(start), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hv [NT];
  logic [W-1:0] yv [FL];
  logic [W-1:0] exp_x [XL];
  logic [W-1:0] got_x [XL];
  logic         exp_mm;
  int           f_lat [XL];
  int           f_nx, f_done;
  logic         f_mm, f_timeout, f_aborted, f_stall_bad, f_stall_yrdy;
  logic         f_busy_start, f_mm_start, f_busy_at_done, f_busy_after;
  logic [W-1:0] saved_h [NT];

  // Direct recursion: x[n] = y[n] - sum h[k]x[n-k]; tail residuals must vanish.
  function automatic void model();
    logic [W-1:0] s;
    exp_mm = 1'b0;
    for (int n = 0; n < FL; n++) begin
      s = yv[n];
      for (int k = 1; k < NT; k++) begin
        if (n - k >= 0 && n - k < XL) s = s - hv[k] * exp_x[n-k];
      end
      if (n < XL) exp_x[n] = s;
      else if (s != '0) exp_mm = 1'b1;
    end
  endfunction

  task automatic load_taps();
    @(negedge clk);
    h_we = 1'b1; h_idx = 3'd0; h_data = 16'hBEEF;
    for (int i = 1; i < NT; i++) begin
      @(negedge clk);
      h_idx = 3'(i); h_data = hv[i];
    end
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic run_frame(input int rdy_pct, input int vld_pct, input int stall_n, input int abort_n);
    int yi, cyc, stall_left;
    logic stall_used, xv_seen, pend_abort;
    logic [W-1:0] stall_val;
    int acc_cyc [FL];
    yi = 0; cyc = 0; stall_left = 0; stall_used = 0; xv_seen = 0; pend_abort = 0; stall_val = '0;
    f_nx = 0; f_done = 0; f_mm = 0; f_timeout = 0; f_aborted = 0;
    f_stall_bad = 0; f_stall_yrdy = 0; f_busy_at_done = 1'b1; f_busy_after = 1'b1;
    for (int i = 0; i < FL; i++) acc_cyc[i] = 0;
    for (int i = 0; i < XL; i++) begin got_x[i] = 'x; f_lat[i] = -1; end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    f_busy_start = busy; f_mm_start = mismatch;
    while (f_done == 0) begin
      if (cyc >= 3000) begin f_timeout = 1'b1; break; end
      if (pend_abort) begin
        rst = 1'b1; f_aborted = 1'b1;
        y_valid = 1'b0; x_ready = 1'b0; start = 1'b0; h_we = 1'b0;
        break;
      end
      if (done) begin f_done = 1; f_mm = mismatch; f_busy_at_done = busy; end
      if (x_valid && !xv_seen && f_nx < XL) begin
        xv_seen = 1'b1; f_lat[f_nx] = cyc - acc_cyc[f_nx];
      end
      if (x_valid && f_nx == stall_n && !stall_used) begin
        stall_used = 1'b1; stall_val = x_data; stall_left = 5;
      end
      if (stall_left > 0) begin
        if (x_data !== stall_val || !x_valid) f_stall_bad = 1'b1;
        if (y_ready) f_stall_yrdy = 1'b1;
        x_ready = 1'b0; start = 1'b1;
        h_we = 1'b1; h_idx = 3'd1; h_data = 16'h7777;
        stall_left--;
      end else begin
        start = 1'b0; h_we = 1'b0;
        x_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      if (x_valid && x_ready && f_nx < XL) begin
        got_x[f_nx] = x_data; f_nx++; xv_seen = 1'b0;
      end
      y_valid = (yi < FL) && ($urandom_range(0, 99) < vld_pct);
      y_data  = y_valid ? yv[yi] : 16'($urandom);
      if (y_valid && y_ready) begin
        acc_cyc[yi] = cyc;
        if (yi == abort_n) pend_abort = 1'b1;
        yi++;
      end
      cyc++;
      @(negedge clk);
    end
    if (!f_aborted) begin
      y_valid = 1'b0; x_ready = 1'b0; start = 1'b0; h_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) f_done++;
      end
      f_busy_after = busy;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({y_ready, x_valid, x_data, busy, done, mismatch} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got y_ready=%b x_valid=%b x_data=%h busy=%b done=%b mismatch=%b exp all 0",
               y_ready, x_valid, x_data, busy, done, mismatch);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({y_ready, x_valid, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got y_ready=%b x_valid=%b busy=%b done=%b exp 0", y_ready, x_valid, busy, done);
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < NT; i++) hv[i] = '0;
    hv[0] = 16'd1; hv[1] = 16'd2;
    for (int i = 0; i < FL; i++) yv[i] = '0;
    yv[0] = 16'd3; yv[1] = 16'd10; yv[2] = 16'd8;
  endtask

  task automatic test_basic();
    set_basic();
    load_taps();
    model();
    run_frame(100, 100, -1, -1);
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL basic_x[%0d] got %h exp %h", i, got_x[i], exp_x[i]); end
    end
    checks++;
    if (got_x[1] !== 16'd4) begin errors++; $display("FAIL basic_x1_const got %h exp 0004", got_x[1]); end
    checks++;
    if (f_timeout || f_nx != XL) begin errors++; $display("FAIL basic_count got %0d timeout=%b exp %0d", f_nx, f_timeout, XL); end
    checks++;
    if (f_mm !== 1'b0) begin errors++; $display("FAIL basic_mismatch got %b exp 0", f_mm); end
    checks++;
    if (f_done != 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", f_done); end
    checks++;
    if (f_busy_start !== 1'b1 || f_busy_at_done !== 1'b0 || f_busy_after !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got start=%b at_done=%b after=%b exp 1 0 0", f_busy_start, f_busy_at_done, f_busy_after);
    end
    checks++;
    if (f_lat[0] != 1) begin errors++; $display("FAIL basic_latency_n0 got %0d exp 1", f_lat[0]); end
  endtask

  task automatic test_wrap();
    set_basic();
    yv[0] = 16'hFFFF; yv[1] = 16'h0000; yv[2] = 16'h0000;
    model();
    run_frame(70, 70, -1, -1);
    checks++;
    if (got_x[0] !== 16'hFFFF || got_x[1] !== 16'h0002) begin
      errors++; $display("FAIL wrap_x01 got %h %h exp ffff 0002", got_x[0], got_x[1]);
    end
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL wrap_x[%0d] got %h exp %h", i, got_x[i], exp_x[i]); end
    end
    checks++;
    if (f_mm !== exp_mm || f_timeout) begin errors++; $display("FAIL wrap_mismatch got %b timeout=%b exp %b", f_mm, f_timeout, exp_mm); end
  endtask

  task automatic test_full_kernel();
    for (int i = 0; i < NT; i++) hv[i] = 16'd1;
    for (int i = 0; i < FL; i++) yv[i] = (i < XL) ? 16'(i + 1) : 16'(FL - i);
    load_taps();
    model();
    run_frame(100, 100, -1, -1);
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== 16'd1) begin errors++; $display("FAIL full_x[%0d] got %h exp 0001", i, got_x[i]); end
    end
    checks++;
    if (f_lat[7] != 8) begin errors++; $display("FAIL full_latency_n7 got %0d exp 8", f_lat[7]); end
    checks++;
    if (f_mm !== 1'b0 || f_done != 1 || f_timeout) begin
      errors++; $display("FAIL full_end got mismatch=%b done=%0d timeout=%b exp 0 1 0", f_mm, f_done, f_timeout);
    end
  endtask

  task automatic test_tail_mismatch();
    set_basic();
    yv[8] = 16'd5;
    load_taps();
    model();
    run_frame(60, 60, -1, -1);
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL tail_x[%0d] got %h exp %h", i, got_x[i], exp_x[i]); end
    end
    checks++;
    if (f_mm !== 1'b1 || f_done != 1) begin errors++; $display("FAIL tail_mismatch got %b done=%0d exp 1 1", f_mm, f_done); end
    checks++;
    if (mismatch !== 1'b1) begin errors++; $display("FAIL tail_mismatch_held got %b exp 1", mismatch); end
    set_basic();
    model();
    run_frame(100, 100, -1, -1);
    checks++;
    if (f_mm_start !== 1'b0 || f_mm !== 1'b0) begin
      errors++; $display("FAIL tail_cleared got after_start=%b at_done=%b exp 0 0", f_mm_start, f_mm);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NT; i++) hv[i] = 16'($urandom);
    for (int i = 0; i < FL; i++) yv[i] = 16'($urandom);
    load_taps();
    model();
    run_frame(80, 80, 2, -1);
    checks++;
    if (f_stall_bad) begin errors++; $display("FAIL bp_x_stable got unstable x_data/x_valid exp stable"); end
    checks++;
    if (f_stall_yrdy) begin errors++; $display("FAIL bp_y_ready got 1 during stall exp 0"); end
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL bp_x[%0d] got %h exp %h", i, got_x[i], exp_x[i]); end
    end
    checks++;
    if (f_mm !== exp_mm || f_done != 1 || f_timeout) begin
      errors++; $display("FAIL bp_end got mismatch=%b done=%0d timeout=%b exp %b 1 0", f_mm, f_done, f_timeout, exp_mm);
    end
    for (int i = 0; i < FL; i++) yv[i] = 16'($urandom);
    model();
    run_frame(100, 100, -1, -1);
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL bp_taps_kept_x[%0d] got %h exp %h", i, got_x[i], exp_x[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    set_basic();
    load_taps();
    run_frame(100, 100, -1, 4);
    #1;
    checks++;
    if (!f_aborted || {y_ready, x_valid, x_data, busy, done, mismatch} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got aborted=%b y_ready=%b x_valid=%b x_data=%h busy=%b done=%b mismatch=%b exp 1 then 0",
               f_aborted, y_ready, x_valid, x_data, busy, done, mismatch);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NT; i++) hv[i] = '0;
    for (int i = 0; i < FL; i++) yv[i] = 16'($urandom);
    model();
    run_frame(100, 100, -1, -1);
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== yv[i]) begin errors++; $display("FAIL midreset_taps_cleared_x[%0d] got %h exp %h", i, got_x[i], yv[i]); end
    end
    set_basic();
    load_taps();
    model();
    run_frame(100, 100, -1, -1);
    for (int i = 0; i < XL; i++) begin
      checks++;
      if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL midreset_reload_x[%0d] got %h exp %h", i, got_x[i], exp_x[i]); end
    end
    checks++;
    if (f_mm !== 1'b0 || f_done != 1) begin errors++; $display("FAIL midreset_reload_end got mismatch=%b done=%0d exp 0 1", f_mm, f_done); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NT; i++) hv[i] = (f[0]) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      for (int i = 0; i < FL; i++) yv[i] = 16'($urandom);
      load_taps();
      model();
      run_frame(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), -1, -1);
      for (int i = 0; i < XL; i++) begin
        checks++;
        if (got_x[i] !== exp_x[i]) begin errors++; $display("FAIL rand%0d_x[%0d] got %h exp %h", f, i, got_x[i], exp_x[i]); end
      end
      checks++;
      if (f_mm !== exp_mm || f_done != 1 || f_timeout) begin
        errors++; $display("FAIL rand%0d_end got mismatch=%b done=%0d timeout=%b exp %b 1 0", f, f_mm, f_done, f_timeout, exp_mm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_full_kernel();
    test_tail_mismatch();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
